// File: rtl/led_mode_controller.sv
// Button-driven OFF/BLINK/ON controller for a single LED.
// Shared state and timer definitions live in led_mode_pkg below.
package led_mode_pkg;

    typedef enum logic [1:0] {
        STATE_OFF   = 2'd0,
        STATE_BLINK = 2'd1,
        STATE_ON    = 2'd2
    } state_t;

    localparam int DEFAULT_CLOCK_FREQUENCY_HZ = 50_000_000;

    // Clock cycles between LED toggles for a given blink rate.
    function automatic int timer_frequency(
        input int clock_hz,
        input int rate_hz
    );
        return clock_hz / rate_hz;
    endfunction

    localparam int TIMER_FREQUENCY_1HZ  =
        timer_frequency(DEFAULT_CLOCK_FREQUENCY_HZ, 1);
    localparam int TIMER_FREQUENCY_2HZ  =
        timer_frequency(DEFAULT_CLOCK_FREQUENCY_HZ, 2);
    localparam int TIMER_FREQUENCY_5HZ  =
        timer_frequency(DEFAULT_CLOCK_FREQUENCY_HZ, 5);
    localparam int TIMER_FREQUENCY_10HZ =
        timer_frequency(DEFAULT_CLOCK_FREQUENCY_HZ, 10);

endpackage

module led_mode_controller
    import led_mode_pkg::*;
#(
    parameter int CLOCK_FREQUENCY_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_off,
    input  logic       button_on,
    input  logic       button_blink,
    input  logic [1:0] freq_sel,
    output logic       led,
    output logic [1:0] state
);

    localparam int CW = $clog2(CLOCK_FREQUENCY_HZ);

    localparam logic [CW-1:0] LIMIT_1HZ  =
        CW'(timer_frequency(CLOCK_FREQUENCY_HZ, 1) - 1);
    localparam logic [CW-1:0] LIMIT_2HZ  =
        CW'(timer_frequency(CLOCK_FREQUENCY_HZ, 2) - 1);
    localparam logic [CW-1:0] LIMIT_5HZ  =
        CW'(timer_frequency(CLOCK_FREQUENCY_HZ, 5) - 1);
    localparam logic [CW-1:0] LIMIT_10HZ =
        CW'(timer_frequency(CLOCK_FREQUENCY_HZ, 10) - 1);

    logic [2:0]    btn_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    prev;
    logic [2:0]    press;

    state_t        state_q;
    state_t        state_next;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic          led_q;
    logic          led_next;
    logic [CW-1:0] limit;

    assign btn_raw = {button_blink, button_on, button_off};

    // Reset to all ones so a button held through reset is not a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = sync2 & ~prev;

    always_comb begin
        limit = LIMIT_1HZ;
        unique case (freq_sel)
            2'd0:    limit = LIMIT_1HZ;
            2'd1:    limit = LIMIT_2HZ;
            2'd2:    limit = LIMIT_5HZ;
            default: limit = LIMIT_10HZ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= STATE_OFF;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            led_q   <= led_next;
        end
    end

    always_comb begin
        state_next = state_q;
        cnt_next   = '0;
        led_next   = 1'b0;

        priority case (1'b1)
            press[0]: state_next = STATE_OFF;
            press[1]: state_next = STATE_ON;
            press[2]: state_next = STATE_BLINK;
            default:  state_next = state_q;
        endcase

        unique case (state_next)
            STATE_OFF: led_next = 1'b0;
            STATE_ON:  led_next = 1'b1;
            STATE_BLINK: begin
                if (state_q != STATE_BLINK) begin
                    led_next = 1'b1;
                end else if (cnt_q >= limit) begin
                    led_next = ~led_q;
                end else begin
                    cnt_next = cnt_q + 1'b1;
                    led_next = led_q;
                end
            end
            default: led_next = 1'b0;
        endcase
    end

    assign led   = led_q;
    assign state = state_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller at a 100 Hz clock.
// Checks use immediate assertions one cycle-step at a time.
module tb_led_mode_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       button_off;
    logic       button_on;
    logic       button_blink;
    logic [1:0] freq_sel;
    logic       led;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    led_mode_controller #(
        .CLOCK_FREQUENCY_HZ(100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_off   (button_off),
        .button_on    (button_on),
        .button_blink (button_blink),
        .freq_sel     (freq_sel),
        .led          (led),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(
        input string      tag,
        input logic [1:0] obs,
        input logic [1:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_sl(
        input string      tag,
        input logic [1:0] exp_state,
        input logic       exp_led
    );
        chk({tag, " state"}, state, exp_state);
        chk({tag, " led"}, {1'b0, led}, {1'b0, exp_led});
    endtask

    initial begin
        reset        = 1'b1;
        button_off   = 1'b0;
        button_on    = 1'b1;
        button_blink = 1'b0;
        freq_sel     = 2'd0;

        // Reset with button_on held; it must not count as a press.
        steps(2);
        chk_sl("reset", 2'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_sl("held_after_reset", 2'd0, 1'b0);
        end
        button_on = 1'b0;
        steps(3);
        chk_sl("released", 2'd0, 1'b0);

        button_on = 1'b1;
        step();
        chk_sl("on_k", 2'd0, 1'b0);
        step();
        chk_sl("on_k1", 2'd0, 1'b0);
        step();
        chk_sl("on_k2", 2'd2, 1'b1);
        button_on = 1'b0;

        // Blink at 10 Hz: toggle every 10 cycles.
        freq_sel     = 2'd3;
        button_blink = 1'b1;
        steps(2);
        chk_sl("blink_k1", 2'd2, 1'b1);
        step();
        chk_sl("blink_entry", 2'd1, 1'b1);
        button_blink = 1'b0;
        steps(9);
        chk_sl("blink_e9", 2'd1, 1'b1);
        step();
        chk_sl("blink_e10", 2'd1, 1'b0);
        steps(9);
        chk_sl("blink_e19", 2'd1, 1'b0);
        step();
        chk_sl("blink_e20", 2'd1, 1'b1);
        steps(10);
        chk_sl("blink_e30", 2'd1, 1'b0);

        // Re-press blink with counter at 7; next toggle still at e+40.
        steps(5);
        button_blink = 1'b1;
        steps(3);
        chk_sl("repress_e38", 2'd1, 1'b0);
        button_blink = 1'b0;
        step();
        chk_sl("repress_e39", 2'd1, 1'b0);
        step();
        chk_sl("repress_e40", 2'd1, 1'b1);

        // Slow to 1 Hz, then switch to 5 Hz with counter at 30.
        freq_sel = 2'd0;
        steps(30);
        chk_sl("rate_cnt30", 2'd1, 1'b1);
        freq_sel = 2'd2;
        step();
        chk_sl("rate_forced", 2'd1, 1'b0);
        steps(19);
        chk_sl("rate_e19", 2'd1, 1'b0);
        step();
        chk_sl("rate_e20", 2'd1, 1'b1);

        // Reset colliding with an ON press while blinking with led=1.
        button_on = 1'b1;
        step();
        chk_sl("pre_reset", 2'd1, 1'b1);
        reset = 1'b1;
        step();
        chk_sl("reset_mid_blink", 2'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_sl("no_on_after_reset", 2'd0, 1'b0);
        end
        button_on = 1'b0;
        steps(3);

        // Blink restarts with a cleared counter after that reset.
        freq_sel     = 2'd3;
        button_blink = 1'b1;
        steps(3);
        button_blink = 1'b0;
        chk_sl("reblink_entry", 2'd1, 1'b1);
        steps(9);
        chk_sl("reblink_e9", 2'd1, 1'b1);
        step();
        chk_sl("reblink_e10", 2'd1, 1'b0);

        // Priority: everything pressed from ON goes to OFF.
        button_on = 1'b1;
        steps(3);
        chk_sl("prio_setup_on", 2'd2, 1'b1);
        button_on = 1'b0;
        steps(3);
        button_off   = 1'b1;
        button_on    = 1'b1;
        button_blink = 1'b1;
        steps(3);
        chk_sl("prio_all", 2'd0, 1'b0);
        button_off   = 1'b0;
        button_on    = 1'b0;
        button_blink = 1'b0;
        steps(3);
        button_on    = 1'b1;
        button_blink = 1'b1;
        steps(2);
        chk_sl("prio_on_blink_k1", 2'd0, 1'b0);
        step();
        chk_sl("prio_on_blink", 2'd2, 1'b1);
        button_on    = 1'b0;
        button_blink = 1'b0;
        steps(12);
        chk_sl("prio_on_stable", 2'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
